uart_tx_arbiter: RTL and testbench

Round-robin arbiter that shares the single UART transmitter in `top` between several byte-stream requesters, such as the echo path, the LED status reporter and the timer heartbeat. It holds the grant for a whole packet, delimited by `req_last`, so messages are never interleaved on `uart_tx_path`. Each packet is capped at a maximum burst length, and a starved packet is abandoned after an idle timeout. It sits between the requesters and the UART TX core and drives that core's start/data handshake.

---
 rtl/uart_tx_arbiter.sv | 178 +++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Round-robin arbiter that shares one UART TX core between NUM_REQ byte-stream
// requesters. A grant is held for a whole packet (closed by req_last), capped at
// MAX_BURST bytes, and dropped if the granted requester stays idle for TIMEOUT
// cycles mid-packet. Drives the TX core's start/data handshake.
//
// Ports:
//   i_clk_in        system clock, rising edge
//   i_reset_n       asynchronous active-low reset
//   i_req_valid     per-requester byte available
//   i_req_data      requester i's byte at [8i+7:8i]
//   i_req_last      offered byte closes its packet
//   o_req_ready     byte accepted this cycle (combinational)
//   o_tx_data       byte presented to the TX core
//   o_tx_start      one-cycle start pulse to the TX core
//   i_tx_busy       TX core is transmitting
//   o_grant_id      current or most recent grantee
//   o_grant_active  a grant is held
module uart_tx_arbiter #(
   parameter int unsigned NUM_REQ   = 3,
   parameter int unsigned MAX_BURST = 16,
   parameter int unsigned TIMEOUT   = 1000
) (
   input  logic                       i_clk_in,
   input  logic                       i_reset_n,
   input  logic [NUM_REQ-1:0]         i_req_valid,
   input  logic [NUM_REQ*8-1:0]       i_req_data,
   input  logic [NUM_REQ-1:0]         i_req_last,
   output logic [NUM_REQ-1:0]         o_req_ready,
   output logic [7:0]                 o_tx_data,
   output logic                       o_tx_start,
   input  logic                       i_tx_busy,
   output logic [$clog2(NUM_REQ)-1:0] o_grant_id,
   output logic                       o_grant_active
);

   localparam int unsigned GW = $clog2(NUM_REQ);
   localparam int unsigned BW = $clog2(MAX_BURST + 1);
   localparam int unsigned IW = $clog2(TIMEOUT);

   typedef enum logic [1:0] {
      StIdle,
      StSend,
      StWaitAck,
      StWaitDone
   } state_e;

   state_e        r_state;
   logic [GW-1:0] r_grant_id;
   logic [GW-1:0] r_last_grant;
   logic          r_grant_active;
   logic          r_tx_start;
   logic [7:0]    r_tx_data;
   logic          r_last_flag;
   logic [BW-1:0] r_burst_cnt;
   logic [IW-1:0] r_idle_cnt;

   logic          w_gnt_valid;
   logic          w_gnt_last;
   logic [7:0]    w_gnt_data;
   logic          w_xfer;
   logic          w_any_valid;
   logic          w_has_hi;
   logic          w_has_lo;
   logic [GW-1:0] w_sel_hi;
   logic [GW-1:0] w_sel_lo;
   logic [GW-1:0] w_next_grant;

   // Select the granted requester's signals and drive its ready bit only.
   always_comb begin
      w_gnt_valid = 1'b0;
      w_gnt_last  = 1'b0;
      w_gnt_data  = 8'h00;
      o_req_ready = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (r_grant_id == GW'(i)) begin
            w_gnt_valid    = i_req_valid[i];
            w_gnt_last     = i_req_last[i];
            w_gnt_data     = i_req_data[8*i +: 8];
            o_req_ready[i] = (r_state == StSend) && !i_tx_busy;
         end
      end
   end

   assign w_xfer      = (r_state == StSend) && !i_tx_busy && w_gnt_valid;
   assign w_any_valid = |i_req_valid;

   // Rotating priority: the lowest valid index above last_grant wins; if there
   // is none, wrap around to the lowest valid index at or below it.
   always_comb begin
      w_has_hi = 1'b0;
      w_has_lo = 1'b0;
      w_sel_hi = '0;
      w_sel_lo = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (i_req_valid[i]) begin
            if (GW'(i) > r_last_grant) begin
               if (!w_has_hi) begin
                  w_has_hi = 1'b1;
                  w_sel_hi = GW'(i);
               end
            end else if (!w_has_lo) begin
               w_has_lo = 1'b1;
               w_sel_lo = GW'(i);
            end
         end
      end
      w_next_grant = w_has_hi ? w_sel_hi : w_sel_lo;
   end

   always_ff @(posedge i_clk_in or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_state        <= StIdle;
         r_grant_id     <= '0;
         r_last_grant   <= GW'(NUM_REQ - 1);
         r_grant_active <= 1'b0;
         r_tx_start     <= 1'b0;
         r_tx_data      <= 8'h00;
         r_last_flag    <= 1'b0;
         r_burst_cnt    <= '0;
         r_idle_cnt     <= '0;
      end else begin
         r_tx_start <= 1'b0;
         unique case (r_state)
            StIdle: begin
               if (w_any_valid) begin
                  r_grant_id     <= w_next_grant;
                  r_grant_active <= 1'b1;
                  r_burst_cnt    <= '0;
                  r_idle_cnt     <= '0;
                  r_state        <= StSend;
               end
            end
            StSend: begin
               if (w_xfer) begin
                  r_tx_data   <= w_gnt_data;
                  r_tx_start  <= 1'b1;
                  r_last_flag <= w_gnt_last;
                  r_burst_cnt <= r_burst_cnt + BW'(1);
                  r_idle_cnt  <= '0;
                  r_state     <= StWaitAck;
               end else if (!w_gnt_valid) begin
                  // Starved mid-packet: give the UART to someone else.
                  if (r_idle_cnt == IW'(TIMEOUT - 1)) begin
                     r_grant_active <= 1'b0;
                     r_last_grant   <= r_grant_id;
                     r_state        <= StIdle;
                  end else begin
                     r_idle_cnt <= r_idle_cnt + IW'(1);
                  end
               end
            end
            StWaitAck: begin
               if (i_tx_busy) begin
                  r_state <= StWaitDone;
               end
            end
            StWaitDone: begin
               if (!i_tx_busy) begin
                  if (r_last_flag || (r_burst_cnt == BW'(MAX_BURST))) begin
                     r_grant_active <= 1'b0;
                     r_last_grant   <= r_grant_id;
                     r_state        <= StIdle;
                  end else begin
                     r_state <= StSend;
                  end
               end
            end
         endcase
      end
   end

   assign o_tx_data      = r_tx_data;
   assign o_tx_start     = r_tx_start;
   assign o_grant_id     = r_grant_id;
   assign o_grant_active = r_grant_active;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter
// Scoreboard bench for uart_tx_arbiter. Requesters are byte queues; a
// packet-level reference model predicts the (grantee, byte) sequence seen at each
// tx_start, and a monitor compares it. A simple TX core model drives tx_busy.
module tb_uart_tx_arbiter;

   localparam int unsigned NUM_REQ   = 3;
   localparam int unsigned MAX_BURST = 4;
   localparam int unsigned TIMEOUT   = 8;
   localparam int unsigned GW        = $clog2(NUM_REQ);

   logic                 clk = 1'b0;
   logic                 reset_n;
   logic [NUM_REQ-1:0]   req_valid;
   logic [NUM_REQ*8-1:0] req_data;
   logic [NUM_REQ-1:0]   req_last;
   logic [NUM_REQ-1:0]   req_ready;
   logic [7:0]           tx_data;
   logic                 tx_start;
   logic                 tx_busy;
   logic [GW-1:0]        grant_id;
   logic                 grant_active;

   int checks = 0;
   int errors = 0;

   // Per-requester pending bytes {last, data}: drv_q is what the requester still
   // offers, mdl_q is what the reference model has not yet scheduled.
   logic [8:0] drv_q[NUM_REQ][$];
   logic [8:0] mdl_q[NUM_REQ][$];
   int         exp_q[$];
   int         mdl_lg = NUM_REQ - 1;
   int         tx_len_force = 0;
   int         rdy0_cnt = 0;

   uart_tx_arbiter #(
      .NUM_REQ  (NUM_REQ),
      .MAX_BURST(MAX_BURST),
      .TIMEOUT  (TIMEOUT)
   ) dut (
      .i_clk_in      (clk),
      .i_reset_n     (reset_n),
      .i_req_valid   (req_valid),
      .i_req_data    (req_data),
      .i_req_last    (req_last),
      .o_req_ready   (req_ready),
      .o_tx_data     (tx_data),
      .o_tx_start    (tx_start),
      .i_tx_busy     (tx_busy),
      .o_grant_id    (grant_id),
      .o_grant_active(grant_active)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0h, want %0h", name, act, req);
      end
   endtask

   task automatic load(input int r, input logic [7:0] d, input bit last);
      drv_q[r].push_back({last, d});
      mdl_q[r].push_back({last, d});
   endtask

   // Packet-level arbitration: next non-empty requester after the last grantee;
   // it keeps the grant until its packet ends, MAX_BURST bytes have gone, or it
   // runs dry mid-packet (which the DUT resolves by timing out).
   task automatic model_run();
      int g;
      int n;
      int c;
      bit done;
      logic [8:0] it;
      while (1) begin
         g = -1;
         for (int k = 1; k <= int'(NUM_REQ); k++) begin
            c = (mdl_lg + k) % int'(NUM_REQ);
            if (g < 0 && mdl_q[c].size() != 0) g = c;
         end
         if (g < 0) break;
         n = 0;
         done = 1'b0;
         while (!done) begin
            it = mdl_q[g].pop_front();
            exp_q.push_back(g * 256 + int'(it[7:0]));
            n++;
            done = it[8] || (n == int'(MAX_BURST)) || (mdl_q[g].size() == 0);
         end
         mdl_lg = g;
      end
   endtask

   function automatic int pending();
      int s = 0;
      for (int i = 0; i < int'(NUM_REQ); i++) s += drv_q[i].size();
      return s;
   endfunction

   task automatic check_reset(input string tag);
      check_eq({tag, "_tx_start"}, int'(tx_start), 0);
      check_eq({tag, "_tx_data"}, int'(tx_data), 0);
      check_eq({tag, "_req_ready"}, int'(req_ready), 0);
      check_eq({tag, "_grant_id"}, int'(grant_id), 0);
      check_eq({tag, "_grant_active"}, int'(grant_active), 0);
   endtask

   task automatic wait_busy(input logic level, input string name);
      int cyc = 0;
      while (tx_busy !== level && cyc < 200) begin
         @(negedge clk);
         cyc++;
      end
      check_eq(name, int'(tx_busy), int'(level));
   endtask

   task automatic run_round(input string name);
      int cyc = 0;
      while ((exp_q.size() != 0 || grant_active || tx_busy || pending() != 0) && cyc < 3000) begin
         @(negedge clk);
         cyc++;
      end
      check_eq({name, "_expected_left"}, exp_q.size(), 0);
      check_eq({name, "_bytes_left"}, pending(), 0);
      repeat (2) @(negedge clk);
   endtask

   // Requesters: sample the handshake just before the edge, then retire the
   // accepted byte and present the next one.
   initial begin
      logic [NUM_REQ-1:0] acc;
      req_valid = '0;
      req_data  = '0;
      req_last  = '0;
      forever begin
         @(negedge clk);
         #4;
         acc = req_valid & req_ready;
         @(posedge clk);
         #1;
         for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (acc[i]) void'(drv_q[i].pop_front());
            if (drv_q[i].size() != 0) begin
               req_valid[i]        = 1'b1;
               req_data[8*i +: 8]  = drv_q[i][0][7:0];
               req_last[i]         = drv_q[i][0][8];
            end else begin
               req_valid[i] = 1'b0;
               req_last[i]  = 1'b0;
            end
         end
      end
   end

   // TX core: busy rises the cycle after the start pulse; it is not reset.
   initial begin
      int len;
      tx_busy = 1'b0;
      forever begin
         @(negedge clk);
         if (tx_start) begin
            len = (tx_len_force != 0) ? tx_len_force : int'($urandom_range(1, 5));
            @(posedge clk);
            #1 tx_busy = 1'b1;
            repeat (len) @(posedge clk);
            #1 tx_busy = 1'b0;
         end
      end
   end

   // Monitor / scoreboard.
   initial begin
      logic prev_start = 1'b0;
      int   act;
      forever begin
         @(negedge clk);
         if (tx_start) begin
            check_eq("start_while_busy", int'(tx_busy), 0);
            check_eq("start_back_to_back", int'(prev_start), 0);
            act = int'(grant_id) * 256 + int'(tx_data);
            if (exp_q.size() == 0) check_eq("tx_unexpected", act, -1);
            else check_eq("tx_byte", act, exp_q.pop_front());
         end
         prev_start = tx_start;
         if (req_ready[0]) rdy0_cnt++;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      int len;
      int npk;
      int cnt;
      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      check_reset("por");
      reset_n = 1'b1;
      @(negedge clk);

      // Single 1-byte packet.
      rdy0_cnt = 0;
      load(0, 8'hA5, 1'b1);
      model_run();
      wait_busy(1'b1, "t1_busy_rise");
      check_eq("t1_active_while_busy", int'(grant_active), 1);
      run_round("t1");
      check_eq("t1_ready_cycles", rdy0_cnt, 1);

      // Round-robin between two 1-byte streams.
      for (int i = 0; i < 3; i++) begin
         load(0, 8'h11, 1'b1);
         load(1, 8'h22, 1'b1);
      end
      model_run();
      run_round("t2");

      // Packet atomicity.
      load(1, 8'h31, 1'b0);
      load(1, 8'h32, 1'b0);
      load(1, 8'h33, 1'b1);
      load(2, 8'h41, 1'b0);
      load(2, 8'h42, 1'b1);
      model_run();
      run_round("t3");

      // Burst cap: six bytes from req0 cut after MAX_BURST.
      for (int b = 0; b < 6; b++) load(0, 8'(8'h60 + b), b == 5);
      load(1, 8'h71, 1'b0);
      load(1, 8'h72, 1'b1);
      model_run();
      run_round("t4");

      // Timeout: req2 sends one byte without last, then falls silent.
      load(2, 8'h5A, 1'b0);
      model_run();
      cnt = 0;
      while (!(grant_active && grant_id == 2'd2) && cnt < 50) begin
         @(negedge clk);
         cnt++;
      end
      check_eq("t5_grant2", int'(grant_id), 2);
      load(0, 8'h77, 1'b1);
      model_run();
      wait_busy(1'b1, "t5_busy_rise");
      wait_busy(1'b0, "t5_busy_fall");
      // Active for the WAIT_DONE cycle in which busy fell plus TIMEOUT SEND cycles.
      cnt = 0;
      while (grant_active && cnt < 100) begin
         cnt++;
         @(negedge clk);
      end
      check_eq("t5_timeout_cycles", cnt, int'(TIMEOUT) + 1);
      run_round("t5");

      // Reset while the TX core is mid-transmission.
      load(0, 8'hC1, 1'b0);
      load(0, 8'hC2, 1'b0);
      load(0, 8'hC3, 1'b1);
      load(1, 8'hD1, 1'b1);
      load(2, 8'hE1, 1'b1);
      model_run();
      tx_len_force = 12;
      wait_busy(1'b1, "t6_busy_rise");
      @(posedge clk);
      #3 reset_n = 1'b0;
      #1 check_reset("mid");
      exp_q.delete();
      for (int i = 0; i < int'(NUM_REQ); i++) mdl_q[i] = drv_q[i];
      mdl_lg = NUM_REQ - 1;
      model_run();
      @(posedge clk);
      #3 reset_n = 1'b1;
      tx_len_force = 0;
      run_round("t6");

      // Randomized rounds.
      for (int r = 0; r < 15; r++) begin
         for (int i = 0; i < int'(NUM_REQ); i++) begin
            npk = int'($urandom_range(0, 2));
            for (int p = 0; p < npk; p++) begin
               len = int'($urandom_range(1, 6));
               for (int b = 0; b < len; b++) load(i, 8'($urandom), b == len - 1);
            end
         end
         model_run();
         run_round("rand");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
